// File: rtl/ofm_maxpool.sv
// 2x2 max-pool over a 4x4 OFM frame streamed in raster order.
// One pooled result per 2x2 block; frame_done marks the last block.
module ofm_maxpool #(
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] In_OFM,
  output logic          out_valid,
  output logic [DW-1:0] Out_Pool,
  output logic          frame_done
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t        state;
  logic [3:0]    pos;
  logic [DW-1:0] hreg;
  logic [DW-1:0] lb [2];

  logic          odd_col;
  logic          odd_row;
  logic          slot;
  logic [DW-1:0] h;
  logic [DW-1:0] lb_rd;
  logic [DW-1:0] pool;

  assign odd_col = pos[0];
  assign odd_row = pos[2];
  assign slot    = pos[1];

  always_comb begin
    h     = (In_OFM > hreg) ? In_OFM : hreg;
    lb_rd = lb[slot];
    pool  = (lb_rd > h) ? lb_rd : h;
  end

  // Outputs are pulses; Out_Pool keeps its last value between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pos        <= '0;
      hreg       <= '0;
      lb[0]      <= '0;
      lb[1]      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      Out_Pool   <= '0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        pos <= pos + 4'd1;
        unique case (state)
          IDLE: begin
            if (pos == 4'd0)
              state <= COLLECT;
          end
          COLLECT: begin
            if (pos == 4'd15)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        unique case (1'b1)
          !odd_col: begin
            hreg <= In_OFM;
          end
          odd_col && !odd_row: begin
            lb[slot] <= h;
          end
          odd_col && odd_row: begin
            Out_Pool   <= pool;
            out_valid  <= 1'b1;
            frame_done <= (pos == 4'd15);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ofm_maxpool.sv
// Testbench for ofm_maxpool: block-level reference model,
// directed frames and randomized frames with bubbles.
module tb_ofm_maxpool;

  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] In_OFM = '0;
  logic          out_valid;
  logic [DW-1:0] Out_Pool;
  logic          frame_done;

  ofm_maxpool #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .In_OFM    (In_OFM),
    .out_valid (out_valid),
    .Out_Pool  (Out_Pool),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int mpos;
  int frame [16];
  int exp_pool;
  int got_q [$];
  int done_cnt;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Max of 2x2 block (br, bc) of the current frame image.
  function automatic int blk_max(input int br, input int bc);
    int m;
    m = 0;
    for (int r = 2 * br; r < 2 * br + 2; r++)
      for (int c = 2 * bc; c < 2 * bc + 2; c++)
        if (frame[r * 4 + c] > m) m = frame[r * 4 + c];
    return m;
  endfunction

  task automatic step(input bit v, input int d);
    bit ev;
    bit ed;
    in_valid = v;
    In_OFM   = DW'(d);
    @(posedge clk);
    ev = 1'b0;
    ed = 1'b0;
    if (v) begin
      frame[mpos] = d;
      if (mpos % 4 == 1 || mpos % 4 == 3) begin
        if (mpos / 4 == 1 || mpos / 4 == 3) begin
          ev       = 1'b1;
          exp_pool = blk_max(mpos / 8, (mpos % 4) / 2);
          ed       = (mpos == 15);
        end
      end
      mpos = (mpos + 1) % 16;
    end
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(ev));
    check("frame_done", 32'(frame_done), 32'(ed));
    check("out_pool", 32'(Out_Pool), 32'(exp_pool));
    if (out_valid) got_q.push_back(int'(Out_Pool));
    if (frame_done) done_cnt++;
  endtask

  task automatic reset_cycles(input int n, input bit v, input int d);
    rst_n    = 1'b0;
    in_valid = v;
    In_OFM   = DW'(d);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_out_pool", 32'(Out_Pool), 32'd0);
    end
    rst_n    = 1'b1;
    mpos     = 0;
    exp_pool = 0;
  endtask

  task automatic check_seq(input string tag, input int n,
                           input int e [8], input int dones);
    check({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_val"}, 32'(got_q[i]), 32'(e[i]));
    check({tag, "_dones"}, 32'(done_cnt), 32'(dones));
    got_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    mpos     = 0;
    exp_pool = 0;
    done_cnt = 0;
    @(negedge clk);

    reset_cycles(3, 1'b1, 100);

    // Ascending frame; first edge after release accepts p = 0
    for (int p = 0; p < 16; p++) step(1'b1, p);
    step(1'b0, 0);
    check_seq("basic", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 1);

    // Descending frame with two-cycle bubbles
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 15 - p);
      if (p == 3 || p == 10) begin
        step(1'b0, 99);
        step(1'b0, 77);
      end
    end
    check_seq("reverse", 4, '{15, 13, 7, 5, 0, 0, 0, 0}, 1);

    for (int p = 0; p < 16; p++) step(1'b1, 8191);
    check_seq("maxval", 4, '{8191, 8191, 8191, 8191, 0, 0, 0, 0}, 1);

    for (int p = 0; p < 16; p++) step(1'b1, (p == 6) ? 4000 : 0);
    check_seq("onehot", 4, '{0, 4000, 0, 0, 0, 0, 0, 0}, 1);

    for (int p = 0; p < 16; p++) step(1'b1, p);
    for (int p = 0; p < 16; p++) step(1'b1, 2 * p);
    step(1'b0, 0);
    check_seq("b2b", 8, '{5, 7, 13, 15, 10, 14, 26, 30}, 2);

    // Abandon a frame after p = 9
    for (int p = 0; p < 10; p++) step(1'b1, 3000 + p);
    got_q.delete();
    done_cnt = 0;
    @(negedge clk);
    reset_cycles(1, 1'b0, 0);
    for (int p = 0; p < 16; p++) step(1'b1, p);
    step(1'b0, 0);
    check_seq("midrst", 4, '{5, 7, 13, 15, 0, 0, 0, 0}, 1);

    // Random frames with random bubbles, checked by the model
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 16; p++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, int'($urandom_range(0, 8191)));
        step(1'b1, int'($urandom_range(0, 8191)));
      end
    end
    step(1'b0, 0);
    check("rand_frames", 32'(done_cnt), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ofm_maxpool.md
OFM_MAXPOOL -- requirements
Module: ofm_maxpool

Interface
REQ-001 Parameter DW, default 13: width of each OFM sample and each pooled result.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies In_OFM for one cycle; fed directly by the convolution stage's out_valid.
REQ-005 In_OFM  input  DW  unsigned OFM sample.
REQ-006 out_valid  output  1  high for exactly one cycle per pooled result.
REQ-007 Out_Pool  output  DW  unsigned 2x2 max-pool result; valid only while out_valid is high.
REQ-008 frame_done  output  1  high for one cycle, coincident with the 4th out_valid of each frame.

Function
REQ-009 A frame shall be 16 accepted samples forming a 4x4 map in raster order. Position p = 0..15 gives row = p[3:2] and col = p[1:0].
REQ-010 A sample shall be accepted on each rising edge where in_valid = 1. The block has no backpressure.
REQ-011 in_valid low (bubble) shall hold every counter and buffer. No output is produced on a bubble, and bubbles may occur anywhere in a frame.
REQ-012 State machine: IDLE and COLLECT.
- IDLE -> COLLECT on an accepted sample at p = 0.
- COLLECT -> IDLE after the sample at p = 15 is accepted.
- If in_valid = 1 in the cycle after p = 15, that sample shall be taken as p = 0 of the next frame, so back-to-back frames need no gap cycle.
REQ-013 A 4-bit position counter shall increment on every accepted sample and wrap 15 -> 0.
REQ-014 Even col: the sample shall be stored in a horizontal register hreg.
REQ-015 Odd col: h = max(hreg, sample) shall be formed.
- Even row: h is written to line buffer lb[col>>1] (2 entries x DW).
- Odd row: Out_Pool = max(lb[col>>1], h) with out_valid = 1.
REQ-016 Output latency: out_valid and Out_Pool shall be registered and appear on the edge that accepts the completing sample. They are visible in the following cycle.
REQ-017 Results shall be emitted at p = 5, 7, 13 and 15, in this order:
- block (0,0)
- block (0,1)
- block (1,0)
- block (1,1)
REQ-018 Comparisons shall be unsigned. On equal operands the common value is output. No truncation or saturation is applied, since widths are equal.
REQ-019 Out_Pool shall hold its last value when out_valid = 0.
REQ-020 lb and hreg shall not be cleared between frames. Each frame shall overwrite them before reading them.

Reset
REQ-021 While rst_n = 0, the following shall all be 0:
- out_valid, frame_done, Out_Pool
- position counter, hreg, lb[0..1]
- state = IDLE
REQ-022 Reset asserted mid-frame shall abandon the partial frame. The first sample accepted after release shall be p = 0.
REQ-023 No output shall be produced in the cycle in which rst_n is released.

Verification
REQ-024 Reset check: hold rst_n = 0 for 3 cycles with in_valid = 1 and In_OFM = 100 -> out_valid = 0, frame_done = 0, Out_Pool = 0 throughout.
REQ-025 Basic frame: 16 consecutive samples with value = p (0..15) -> out_valid pulses after p = 5, 7, 13 and 15 with Out_Pool = 5, 7, 13, 15; frame_done accompanies the 15.
REQ-026 Reverse frame with bubbles: values 15 - p, with in_valid low for 2 cycles after p = 3 and after p = 10 -> Out_Pool = 15, 13, 7, 5 in order; no pulses during bubbles.
REQ-027 Max width and ties: all 16 samples = 8191 -> four outputs of 8191. Then a frame with only In_OFM[p = 6] = 4000 and all others 0 -> outputs 0, 4000, 0, 0.
REQ-028 Back-to-back frames: frame A values p followed by frame B values 2p with no gap -> outputs 5, 7, 13, 15, 10, 14, 26, 30; two frame_done pulses.
REQ-029 Reset mid-frame: pulse rst_n low after p = 9 of a frame, then send a fresh ascending frame -> no output from the abandoned frame; outputs 5, 7, 13, 15.
